// File: rtl/dram_write_sequencer.sv
// dram_write_sequencer: FIFO-buffered replay of init words into the 16-core DRAM macro with setup/write/precharge timing.
// Optional write counter port WR_COUNT is built when DRAM_WR_CNT_EN is defined.
module dram_write_sequencer #(
  parameter int LANES = 16,
  parameter int DW    = 64,
  parameter int AW    = 6,
  parameter int DEPTH = 64,
  parameter int T_WR  = 4,
  parameter int T_PRE = 2
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                IO_EN,
  input  logic [AW-1:0]       ADDR,
  input  logic [LANES*DW-1:0] WBL_IN,
  output logic [AW-1:0]       WL_ADDR,
  output logic [LANES*DW-1:0] WBL_OUT,
  output logic                WE,
  output logic                PRE,
  output logic                WR_DONE,
  output logic                BUSY,
  output logic                OVERFLOW
`ifdef DRAM_WR_CNT_EN
  ,
  output logic [15:0]         WR_COUNT
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int TM = T_WR > T_PRE ? T_WR : T_PRE;
  localparam int TW = TM > 1 ? $clog2(TM) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, PRECH, ACK} state_t;
  state_t state_q, state_d;
  logic [AW+LANES*DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [AW-1:0] wl_addr_q, wl_addr_d;
  logic [LANES*DW-1:0] wbl_q, wbl_d;
  logic we_q, we_d, pre_q, pre_d, done_q, done_d, ovf_q, ovf_d;
  logic full, push, pop;
`ifdef DRAM_WR_CNT_EN
  logic [15:0] wr_count_q, wr_count_d;
  assign WR_COUNT = wr_count_q;
`endif
  assign WL_ADDR  = wl_addr_q;
  assign WBL_OUT  = wbl_q;
  assign WE       = we_q;
  assign PRE      = pre_q;
  assign WR_DONE  = done_q;
  assign OVERFLOW = ovf_q;
  assign BUSY     = state_q != IDLE || cnt_q != '0;
  always_comb begin
    full  = cnt_q == (PW+1)'(DEPTH);
    push  = IO_EN && !full;
    pop   = (state_q == IDLE || state_q == ACK) && cnt_q != '0;
    wp_d  = wp_q + PW'(push);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    ovf_d = ovf_q | (IO_EN & full);
    {wl_addr_d, wbl_d} = pop ? mem[rp_q] : {wl_addr_q, wbl_q};
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE:  state_d = pop ? SETUP : IDLE;
      SETUP: begin
        state_d = WRITE;
        tmr_d   = TW'(T_WR - 1);
      end
      WRITE: begin
        state_d = tmr_q == '0 ? PRECH : WRITE;
        tmr_d   = tmr_q == '0 ? TW'(T_PRE - 1) : tmr_q - 1'b1;
      end
      PRECH: begin
        state_d = tmr_q == '0 ? ACK : PRECH;
        tmr_d   = tmr_q - 1'b1;
      end
      ACK:     state_d = pop ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
    we_d   = state_d == WRITE;
    pre_d  = state_d == PRECH;
    done_d = state_d == ACK;
`ifdef DRAM_WR_CNT_EN
    wr_count_d = (done_d && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
`endif
  end
  always_ff @(posedge CLK) if (push) mem[wp_q] <= {ADDR, WBL_IN};
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      wl_addr_q <= '0;
      wbl_q     <= '0;
      we_q      <= 1'b0;
      pre_q     <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef DRAM_WR_CNT_EN
      wr_count_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      wl_addr_q <= wl_addr_d;
      wbl_q     <= wbl_d;
      we_q      <= we_d;
      pre_q     <= pre_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
`ifdef DRAM_WR_CNT_EN
      wr_count_q <= wr_count_d;
`endif
    end
  end
endmodule

// File: tb/tb_dram_write_sequencer.sv
// tb_dram_write_sequencer: three parameterisations (default, DEPTH=4, T_WR=T_PRE=1) on shared stimulus,
// each compared every cycle against a queue-and-phase reference model.
module tb_dram_write_sequencer;
  localparam int AW = 6, WD = 1024, WW = AW + WD;
  logic CLK = 1'b0, RSTn = 1'b1, IO_EN = 1'b0;
  logic [AW-1:0] ADDR = '0;
  logic [WD-1:0] WBL_IN = '0;
  logic [AW-1:0] wl [3];
  logic [WD-1:0] wbl [3];
  logic we [3], pre [3], done [3], busy [3], ovo [3];
  logic [15:0] wrc [3];
  logic [WW-1:0] q [3][$];
  logic [WW-1:0] cur [3];
  bit act [3], ovf [3];
  int ph [3], wcnt [3];
  int vec = 0, errs = 0;

  always #5 CLK = ~CLK;

  dram_write_sequencer #(.DEPTH(64), .T_WR(4), .T_PRE(2)) u0 (
    .CLK(CLK), .RSTn(RSTn), .IO_EN(IO_EN), .ADDR(ADDR), .WBL_IN(WBL_IN),
    .WL_ADDR(wl[0]), .WBL_OUT(wbl[0]), .WE(we[0]), .PRE(pre[0]), .WR_DONE(done[0]),
    .BUSY(busy[0]), .OVERFLOW(ovo[0])
`ifdef DRAM_WR_CNT_EN
    , .WR_COUNT(wrc[0])
`endif
  );
  dram_write_sequencer #(.DEPTH(4), .T_WR(4), .T_PRE(2)) u1 (
    .CLK(CLK), .RSTn(RSTn), .IO_EN(IO_EN), .ADDR(ADDR), .WBL_IN(WBL_IN),
    .WL_ADDR(wl[1]), .WBL_OUT(wbl[1]), .WE(we[1]), .PRE(pre[1]), .WR_DONE(done[1]),
    .BUSY(busy[1]), .OVERFLOW(ovo[1])
`ifdef DRAM_WR_CNT_EN
    , .WR_COUNT(wrc[1])
`endif
  );
  dram_write_sequencer #(.DEPTH(64), .T_WR(1), .T_PRE(1)) u2 (
    .CLK(CLK), .RSTn(RSTn), .IO_EN(IO_EN), .ADDR(ADDR), .WBL_IN(WBL_IN),
    .WL_ADDR(wl[2]), .WBL_OUT(wbl[2]), .WE(we[2]), .PRE(pre[2]), .WR_DONE(done[2]),
    .BUSY(busy[2]), .OVERFLOW(ovo[2])
`ifdef DRAM_WR_CNT_EN
    , .WR_COUNT(wrc[2])
`endif
  );

  function automatic int dep(int k);  return k == 1 ? 4 : 64; endfunction
  function automatic int twr(int k);  return k == 2 ? 1 : 4;  endfunction
  function automatic int tpre(int k); return k == 2 ? 1 : 2;  endfunction
  function automatic int len(int k);  return twr(k) + tpre(k) + 2; endfunction
  // ph counts cycles since the pop: 0 setup, 1..T_WR write, then precharge, last = ack
  function automatic bit e_we(int k);   return act[k] && ph[k] >= 1 && ph[k] <= twr(k); endfunction
  function automatic bit e_pre(int k);  return act[k] && ph[k] > twr(k) && ph[k] <= twr(k) + tpre(k); endfunction
  function automatic bit e_done(int k); return act[k] && ph[k] == len(k) - 1; endfunction
  function automatic bit e_busy(int k); return act[k] || q[k].size() > 0; endfunction

  task automatic model_reset;
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      cur[k] = '0; act[k] = 0; ph[k] = 0; ovf[k] = 0; wcnt[k] = 0;
    end
  endtask

  task automatic step;
    @(posedge CLK);
    for (int k = 0; k < 3; k++) begin
      bit full, popn;
      full = q[k].size() == dep(k);
      popn = q[k].size() > 0 && (!act[k] || ph[k] == len(k) - 1);
      if (popn) begin
        cur[k] = q[k].pop_front(); act[k] = 1; ph[k] = 0;
      end else if (act[k]) begin
        if (ph[k] == len(k) - 1) act[k] = 0;
        else begin
          ph[k]++;
          if (ph[k] == len(k) - 1 && wcnt[k] < 65535) wcnt[k]++;
        end
      end
      if (IO_EN) begin
        if (full) ovf[k] = 1;
        else q[k].push_back({ADDR, WBL_IN});
      end
    end
    #1;
  endtask

  task automatic apply_reset;
    RSTn = 1'b0; IO_EN = 1'b0;
    model_reset();
    #7 RSTn = 1'b1;
  endtask

  task automatic rand_data;
    for (int b = 0; b < 32; b++) WBL_IN[b*32 +: 32] = $urandom;
  endtask

  task automatic test_reset;
    #2 RSTn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if ({we[k], pre[k], done[k], busy[k], ovo[k], wl[k], wbl[k]} !== '0) begin
        errs++; $display("FAIL reset u%0d: we=%b pre=%b done=%b busy=%b ovf=%b addr=%h want all 0", k, we[k], pre[k], done[k], busy[k], ovo[k], wl[k]);
      end
`ifdef DRAM_WR_CNT_EN
      vec++;
      if (wrc[k] !== 16'd0) begin errs++; $display("FAIL reset_cnt u%0d: got %0d want 0", k, wrc[k]); end
`endif
    end
    #4 RSTn = 1'b1;
  endtask

  task automatic test_single_word;
    int done_at [3], we_n [3], pre_n [3];
    apply_reset();
    for (int k = 0; k < 3; k++) begin done_at[k] = -1; we_n[k] = 0; pre_n[k] = 0; end
    IO_EN = 1'b1; ADDR = 6'h05; WBL_IN = {16{64'h0123456789abcdef}};
    for (int j = 0; j < 14; j++) begin
      step();
      IO_EN = 1'b0;
      for (int k = 0; k < 3; k++) begin
        vec++;
        if ({we[k], pre[k], done[k], busy[k], ovo[k]} !== {e_we(k), e_pre(k), e_done(k), e_busy(k), ovf[k]}) begin
          errs++; $display("FAIL single_ctl u%0d edge N+%0d: we/pre/done/busy/ovf got %b%b%b%b%b want %b%b%b%b%b", k, j, we[k], pre[k], done[k], busy[k], ovo[k], e_we(k), e_pre(k), e_done(k), e_busy(k), ovf[k]);
        end
        vec++;
        if ({wl[k], wbl[k]} !== cur[k]) begin
          errs++; $display("FAIL single_data u%0d edge N+%0d: addr %h lane0 %h want %h %h", k, j, wl[k], wbl[k][63:0], cur[k][WW-1 -: AW], cur[k][63:0]);
        end
        if (done[k] === 1'b1 && done_at[k] < 0) done_at[k] = j;
        we_n[k] += int'(we[k] === 1'b1);
        pre_n[k] += int'(pre[k] === 1'b1);
      end
    end
    vec++;
    if (done_at[0] != 8 || we_n[0] != 4 || pre_n[0] != 2) begin
      errs++; $display("FAIL single_timing_default: done at N+%0d we %0d pre %0d want N+8 4 2", done_at[0], we_n[0], pre_n[0]);
    end
    vec++;
    if (done_at[2] != 4 || we_n[2] != 1 || pre_n[2] != 1) begin
      errs++; $display("FAIL single_timing_fast: done at N+%0d we %0d pre %0d want N+4 1 1", done_at[2], we_n[2], pre_n[2]);
    end
`ifdef DRAM_WR_CNT_EN
    vec++;
    if (wrc[0] !== 16'd1) begin errs++; $display("FAIL single_cnt: got %0d want 1", wrc[0]); end
`endif
  endtask

  task automatic test_init_burst;
    int n_done = 0, last = -1, j = 0;
    apply_reset();
    for (int w = 0; w < 54; w++) begin
      IO_EN = 1'b1; ADDR = AW'(w); rand_data();
      step();
      j++;
      vec++;
      if ({we[0], pre[0], done[0], busy[0], ovo[0], wl[0], wbl[0]} !== {e_we(0), e_pre(0), e_done(0), e_busy(0), ovf[0], cur[0]}) begin
        errs++; $display("FAIL burst_fill edge %0d: we/pre/done/busy/ovf %b%b%b%b%b addr %h want %b%b%b%b%b %h", j, we[0], pre[0], done[0], busy[0], ovo[0], wl[0], e_we(0), e_pre(0), e_done(0), e_busy(0), ovf[0], cur[0][WW-1 -: AW]);
      end
      if (done[0] === 1'b1) begin
        vec++;
        if (wl[0] !== AW'(n_done) || (last >= 0 && j - last != 8)) begin
          errs++; $display("FAIL burst_order: write %0d addr %0d gap %0d want addr %0d gap 8", n_done, wl[0], j - last, n_done);
        end
        n_done++; last = j;
      end
    end
    IO_EN = 1'b0;
    while (e_busy(0) && j < 600) begin
      step();
      j++;
      vec++;
      if ({we[0], pre[0], done[0], busy[0], ovo[0], wl[0], wbl[0]} !== {e_we(0), e_pre(0), e_done(0), e_busy(0), ovf[0], cur[0]}) begin
        errs++; $display("FAIL burst_drain edge %0d: we/pre/done/busy/ovf %b%b%b%b%b addr %h want %b%b%b%b%b %h", j, we[0], pre[0], done[0], busy[0], ovo[0], wl[0], e_we(0), e_pre(0), e_done(0), e_busy(0), ovf[0], cur[0][WW-1 -: AW]);
      end
      if (done[0] === 1'b1) begin
        vec++;
        if (wl[0] !== AW'(n_done) || j - last != 8) begin
          errs++; $display("FAIL burst_order: write %0d addr %0d gap %0d want addr %0d gap 8", n_done, wl[0], j - last, n_done);
        end
        n_done++; last = j;
      end
    end
    step();
    vec++;
    if (n_done != 54 || ovo[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errs++; $display("FAIL burst_total: writes %0d ovf %b busy %b want 54 0 0", n_done, ovo[0], busy[0]);
    end
`ifdef DRAM_WR_CNT_EN
    vec++;
    if (wrc[0] !== 16'd54) begin errs++; $display("FAIL burst_cnt: got %0d want 54", wrc[0]); end
`endif
  endtask

  task automatic test_overflow;
    int n_done = 0;
    logic [AW-1:0] got [$];
    apply_reset();
    for (int j = 0; j < 80; j++) begin
      IO_EN = j < 8; ADDR = AW'(j + 10); rand_data();
      step();
      vec++;
      if ({we[1], pre[1], done[1], busy[1], ovo[1], wl[1], wbl[1]} !== {e_we(1), e_pre(1), e_done(1), e_busy(1), ovf[1], cur[1]}) begin
        errs++; $display("FAIL ovf_cycle edge %0d: we/pre/done/busy/ovf %b%b%b%b%b addr %h want %b%b%b%b%b %h", j, we[1], pre[1], done[1], busy[1], ovo[1], wl[1], e_we(1), e_pre(1), e_done(1), e_busy(1), ovf[1], cur[1][WW-1 -: AW]);
      end
      vec++;
      if (ovo[1] !== (j >= 5)) begin errs++; $display("FAIL ovf_flag edge %0d: got %b want %b", j, ovo[1], j >= 5); end
      if (done[1] === 1'b1) begin n_done++; got.push_back(wl[1]); end
    end
    vec++;
    if (n_done != 5 || got.size() != 5 || got[0] !== 6'd10 || got[4] !== 6'd14) begin
      errs++; $display("FAIL ovf_writes: got %0d writes want 5 (w0..w4)", n_done);
    end
  endtask

  task automatic test_random_traffic;
    apply_reset();
    for (int j = 0; j < 500; j++) begin
      IO_EN = $urandom_range(0, 3) == 0; ADDR = AW'($urandom); rand_data();
      step();
      for (int k = 0; k < 3; k++) begin
        vec++;
        if ({we[k], pre[k], done[k], busy[k], ovo[k], wl[k], wbl[k]} !== {e_we(k), e_pre(k), e_done(k), e_busy(k), ovf[k], cur[k]}) begin
          errs++; $display("FAIL random u%0d edge %0d: we/pre/done/busy/ovf %b%b%b%b%b addr %h want %b%b%b%b%b %h", k, j, we[k], pre[k], done[k], busy[k], ovo[k], wl[k], e_we(k), e_pre(k), e_done(k), e_busy(k), ovf[k], cur[k][WW-1 -: AW]);
        end
        vec++;
        if (we[k] === 1'b1 && pre[k] === 1'b1) begin errs++; $display("FAIL we_pre_overlap u%0d edge %0d: both high", k, j); end
`ifdef DRAM_WR_CNT_EN
        vec++;
        if (wrc[k] !== 16'(wcnt[k])) begin errs++; $display("FAIL random_cnt u%0d: got %0d want %0d", k, wrc[k], wcnt[k]); end
`endif
      end
    end
  endtask

  task automatic test_reset_mid_write;
    int j = 0;
    apply_reset();
    for (int w = 0; w < 4; w++) begin
      IO_EN = 1'b1; ADDR = AW'(w + 1); rand_data();
      step();
    end
    IO_EN = 1'b0;
    while (we[0] !== 1'b1 && j < 20) begin step(); j++; end
    vec++;
    if (we[0] !== 1'b1) begin errs++; $display("FAIL midrst_setup: we got %b want 1", we[0]); end
    #2 RSTn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if ({we[k], pre[k], done[k], busy[k], ovo[k]} !== 5'b0) begin
        errs++; $display("FAIL midrst_async u%0d: we/pre/done/busy/ovf %b%b%b%b%b want 00000", k, we[k], pre[k], done[k], busy[k], ovo[k]);
      end
    end
    #3 RSTn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        vec++;
        if ({we[k], pre[k], done[k], busy[k], ovo[k]} !== 5'b0) begin
          errs++; $display("FAIL midrst_after u%0d cycle %0d: we/pre/done/busy/ovf %b%b%b%b%b want 00000", k, c, we[k], pre[k], done[k], busy[k], ovo[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_init_burst();
    test_overflow();
    test_random_traffic();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
